// File: rtl/store_flush_controller.sv
`default_nettype none
// ============================================================================
//  Module      : store_flush_controller
//  Description : Sequencer that flushes the four 64-bit rows of the store
//                register bank to main data memory once every core has
//                posted its store word. One request/acknowledge handshake is
//                made per row, the cores are stalled for the whole flush and
//                a one-cycle pulse marks completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_flush_controller #(
    parameter int              MEM_ADDR_W = 8,
    parameter int              NUM_ROWS   = 4,
    parameter logic [3:0]      ROW_BASE   = 4'b1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MEMWR_1,
    input  logic                  MEMWR_2,
    input  logic                  MEMWR_3,
    input  logic                  MEMWR_4,
    input  logic [MEM_ADDR_W-1:0] MEM_BASE_ADDR,
    input  logic                  MEM_ACK,
    output logic                  WRITE_MEM,
    output logic [3:0]            ROW_ADDR,
    output logic                  MEM_WE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDR,
    output logic                  CORE_STALL,
    output logic                  FLUSH_DONE
);

    // Row counter is two bits wide: the bank always has exactly four rows.
    localparam logic [1:0] c_last_row = 2'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Flush trigger: only all four cores ready starts a flush.
    logic w_all_wr;
    assign w_all_wr = MEMWR_1 & MEMWR_2 & MEMWR_3 & MEMWR_4;

    state_t                  state_q,      state_d;
    logic [1:0]              row_q,        row_d;
    logic [MEM_ADDR_W-1:0]   base_q,       base_d;

    logic                    write_mem_q,  write_mem_d;
    logic [3:0]              row_addr_q,   row_addr_d;
    logic                    mem_we_q,     mem_we_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic                    core_stall_q, core_stall_d;
    logic                    flush_done_q, flush_done_d;

    // Next-state logic: row walk with one SELECT cycle and an ack-wait WRITE phase per row.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (w_all_wr) begin
                    // Base is captured once; later changes are ignored until the next flush.
                    base_d  = MEM_BASE_ADDR;
                    row_d   = 2'd0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // Fixed single cycle so the bank's falling-edge latch can present the row.
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (MEM_ACK) begin
                    if (row_q == c_last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Waiting for the trigger to drop prevents a held level from re-flushing.
                if (!w_all_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state they describe.
    always_comb begin
        write_mem_d  = 1'b0;
        row_addr_d   = 4'b0000;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        core_stall_d = 1'b0;
        flush_done_d = 1'b0;
        case (state_d)
            ST_SELECT: begin
                write_mem_d  = 1'b1;
                row_addr_d   = ROW_BASE + {2'b00, row_d};
                core_stall_d = 1'b1;
            end
            ST_WRITE: begin
                write_mem_d  = 1'b1;
                row_addr_d   = ROW_BASE + {2'b00, row_d};
                mem_we_d     = 1'b1;
                // Address wraps modulo 2^MEM_ADDR_W; the carry out is dropped.
                mem_addr_d   = base_d + {{(MEM_ADDR_W-2){1'b0}}, row_d};
                core_stall_d = 1'b1;
            end
            ST_DONE: begin
                core_stall_d = 1'b1;
                flush_done_d = 1'b1;
            end
            default: begin
                write_mem_d  = 1'b0;
            end
        endcase
    end

    // State, row counter, captured base and Moore outputs; reset aborts any flush in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= 2'd0;
            base_q       <= '0;
            write_mem_q  <= 1'b0;
            row_addr_q   <= 4'b0000;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            core_stall_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            base_q       <= base_d;
            write_mem_q  <= write_mem_d;
            row_addr_q   <= row_addr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            core_stall_q <= core_stall_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign WRITE_MEM  = write_mem_q;
    assign ROW_ADDR   = row_addr_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_ADDR   = mem_addr_q;
    assign CORE_STALL = core_stall_q;
    assign FLUSH_DONE = flush_done_q;

endmodule
`default_nettype wire

// File: doc/store_flush_controller.md
# store_flush_controller

Sequencer for the memory-controller store register bank. Waits until all four cores have posted their store words (every `MEMWR_i` high). It then walks the bank's four 64-bit rows (`ROW_ADDR` 4'b1000–4'b1011) out to main data memory, one row at a time, with a request/acknowledge handshake per row. The cores are stalled for the whole flush. A one-cycle completion pulse is raised when the last row has been accepted.

## Interface
Parameters:
- `MEM_ADDR_W`, 8: width of the main-memory row address.
- `NUM_ROWS`, 4: rows flushed per trigger. Fixed at 4 to match the 16×16-bit bank.
- `ROW_BASE`, 4'b1000: `ROW_ADDR` code for row 0. Row k is `ROW_BASE + k`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `MEMWR_1`..`MEMWR_4`  in  1 each  core store-ready levels.
- `MEM_BASE_ADDR`  in  MEM_ADDR_W  main-memory address of row 0.
- `MEM_ACK`  in  1  memory has accepted the current row.
- `WRITE_MEM`  out  1  enables the register bank's output.
- `ROW_ADDR`  out  4  row select to the register bank.
- `MEM_WE`  out  1  row write request to main memory.
- `MEM_ADDR`  out  MEM_ADDR_W  target address of the current row.
- `CORE_STALL`  out  1  holds all cores while a flush is in progress.
- `FLUSH_DONE`  out  1  one-cycle pulse when the flush completes.

## Operation
- The trigger is `ALL_WR` = AND of `MEMWR_1..4`. Three of four high never triggers.
- States: IDLE, SELECT, WRITE, DONE, RELEASE.
- **IDLE**: all outputs inactive; `ROW_ADDR` = 4'b0000, a non-row code, so the bank holds.
  - If `ALL_WR` = 1: capture `MEM_BASE_ADDR`, clear the row counter (2-bit), go to SELECT.
- **SELECT**:
  - `ROW_ADDR` = `ROW_BASE` + row.
  - `WRITE_MEM` = 1, `MEM_WE` = 0, `CORE_STALL` = 1.
  - Always lasts exactly one cycle. This gives the bank's falling-edge output latch a full half-cycle to present the row.
  - Next state: WRITE.
- **WRITE**:
  - Same `ROW_ADDR`, `WRITE_MEM` = 1, `CORE_STALL` = 1.
  - `MEM_WE` = 1, `MEM_ADDR` = captured base + row, modulo 2^MEM_ADDR_W (wraps, no carry out).
  - Held while `MEM_ACK` = 0, with no timeout.
  - When `MEM_ACK` = 1 is sampled: if row < NUM_ROWS−1, increment row and go to SELECT; otherwise go to DONE.
- **DONE**: `FLUSH_DONE` = 1 and `CORE_STALL` = 1 for one cycle; `WRITE_MEM`, `MEM_WE` = 0; `ROW_ADDR` = 0. Next state: RELEASE.
- **RELEASE**: `CORE_STALL` = 0. Stay until `ALL_WR` = 0, then go to IDLE. A level held high never re-triggers a second flush.
- **Simultaneous events**:
  - Changes to `MEM_BASE_ADDR` during a flush are ignored.
  - `MEMWR_i` changes during SELECT/WRITE/DONE are ignored.
  - `MEM_ACK` is ignored outside WRITE.
- **Reset**: `rst_n` low at any time, including mid-flush with `MEM_WE` high, immediately forces IDLE.
  - All outputs go to 0: `WRITE_MEM`, `ROW_ADDR` = 4'b0000, `MEM_WE`, `MEM_ADDR`, `CORE_STALL`, `FLUSH_DONE`.
  - Row counter and captured base are cleared.
  - No partial flush resumes after reset; the next flush requires a fresh trigger.

## Timing
- All outputs are registered (Moore); none depend combinationally on inputs.
- Trigger sampled at edge E0. SELECT outputs are valid after E0. `MEM_WE` for row 0 rises after E1.
- Per row: 1 SELECT cycle + (1 + ack-wait) WRITE cycles. `MEM_WE` drops for exactly one cycle between consecutive rows.
- With `MEM_ACK` tied high, a flush spans 8 cycles (SELECT/WRITE), then 1 DONE cycle:
  - `CORE_STALL` is high for 9 cycles.
  - `FLUSH_DONE` rises 9 cycles after E0.
- Minimum spacing between two flushes is 11 cycles (flush + RELEASE + IDLE), given `ALL_WR` drops then re-rises.
- After reset deasserts, the first trigger can be sampled on the first rising edge.

## Test plan
- **Basic flush**: `ALL_WR` pulsed, base 0x20, `MEM_ACK` tied 1 -> 4 `MEM_WE` pulses with `ROW_ADDR` 1000/1001/1010/1011 and `MEM_ADDR` 0x20–0x23. `FLUSH_DONE` pulse 9 cycles after trigger; `CORE_STALL` high for 9 cycles.
- **Delayed ack**: `MEM_ACK` asserted 3 cycles after each `MEM_WE` rise -> `MEM_WE`/`ROW_ADDR`/`MEM_ADDR` stable while waiting; each row takes 5 cycles; `FLUSH_DONE` 21 cycles after trigger.
- **Partial ready**: `MEMWR_1..3` = 1, `MEMWR_4` = 0 for 20 cycles -> FSM stays IDLE, all outputs 0. Raising `MEMWR_4` starts a flush next cycle.
- **Held level**: `ALL_WR` held high for 40 cycles -> exactly one flush and one `FLUSH_DONE`. A second flush starts only after `ALL_WR` drops and re-rises.
- **Address wrap**: base 0xFE -> `MEM_ADDR` sequence 0xFE, 0xFF, 0x00, 0x01.
- **Reset mid-flush**: `rst_n` low during row 2 WRITE with `MEM_WE` = 1 -> all outputs 0 asynchronously. After release, no activity until a new trigger; the new flush starts at row 0 (`ROW_ADDR` 1000).
